// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver that pairs with the team UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional build macro UART_RX_MAJORITY_EN: each sample point takes a 2-of-3 vote
// over the cycles around the bit centre; the state advance moves one cycle later.

package uart_pkg;
  typedef enum logic [1:0] {NONE, EVEN, ODD} parity_t;
endpackage

module uart_rx #(
  parameter int                CLOCKRATE = 100,
  parameter int                BAUDRATE  = 9600,
  parameter int                DATA_BITS = 8,
  parameter uart_pkg::parity_t PARITY    = uart_pkg::NONE,
  parameter int                STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int CNTLIMIT = CLOCKRATE * 1000000 / BAUDRATE;
  localparam int HALF     = CNTLIMIT / 2;
  localparam int CW       = $clog2(CNTLIMIT + 1);
  localparam int IW       = $clog2(DATA_BITS + 1);

  // The counter is loaded with a bit time and counts down; "expiry" is the cycle in
  // which it steps from 1 to 0. With majority voting the decision is taken one cycle
  // later (count at 0), so the reload is one shorter to keep the bit pitch exact.
`ifdef UART_RX_MAJORITY_EN
  localparam int FIRE_AT = 0;
  localparam int RELOAD  = CNTLIMIT - 1;
`else
  localparam int FIRE_AT = 1;
  localparam int RELOAD  = CNTLIMIT;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s, rx_s_d1;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_BITS-1:0]  shift;
  logic                  par_bad, stop_bad;
  logic                  fire, bit_now, fall, last_data, last_stop;
  logic                  load_half, load_bit, shift_en, par_en, stop_en, done;

`ifdef UART_RX_MAJORITY_EN
  logic rx_s_d2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // extra history tap so the vote covers expiry-1, expiry and expiry+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_s_d2 <= 1'b1;
    else     rx_s_d2 <= rx_s_d1;
  end

  assign bit_now = maj3(rx_s_d2, rx_s_d1, rx_s);
`else
  assign bit_now = rx_s;
`endif

  assign fire      = (cnt == CW'(FIRE_AT));
  assign fall      = rx_s_d1 & ~rx_s;
  assign last_data = (idx == IW'(DATA_BITS - 1));
  assign last_stop = (idx == IW'(STOP_BITS - 1));

  // two-flop synchronizer plus previous-sample tap for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d1 <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d1 <= rx_s;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (rx_en && fall) state_nxt = START;
      START:      if (fire) state_nxt = bit_now ? IDLE : DATA;
      DATA:       if (fire && last_data)
                    state_nxt = (PARITY != uart_pkg::NONE) ? PARITY_BIT : STOP;
      PARITY_BIT: if (fire) state_nxt = STOP;
      STOP:       if (fire && last_stop) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // per-state datapath strobes
  always_comb begin
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:       load_half = rx_en & fall;
      START:      load_bit  = fire & ~bit_now;
      DATA:       begin
                    shift_en = fire;
                    load_bit = fire;
                  end
      PARITY_BIT: begin
                    par_en   = fire;
                    load_bit = fire;
                  end
      STOP:       begin
                    stop_en  = fire;
                    load_bit = fire & ~last_stop;
                    done     = fire & last_stop;
                  end
      default:    ;
    endcase
  end

  // bit timer, bit index, shift register, error latches and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid <= done;

      if (load_half)      cnt <= CW'(HALF);
      else if (load_bit)  cnt <= CW'(RELOAD);
      else if (cnt != '0) cnt <= cnt - CW'(1);

      if (load_half) begin
        idx      <= '0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end

      // LSB arrives first, so shifting in from the top leaves it at bit 0
      if (shift_en) begin
        shift <= {bit_now, shift[DATA_BITS-1:1]};
        idx   <= last_data ? '0 : idx + IW'(1);
      end

      if (par_en)
        par_bad <= (PARITY == uart_pkg::ODD) ? ~(^shift ^ bit_now) : (^shift ^ bit_now);

      if (stop_en) begin
        idx <= last_stop ? '0 : idx + IW'(1);
        if (!bit_now) stop_bad <= 1'b1;
      end

      // the final stop sample is folded in directly since its latch is not yet visible
      if (done) begin
        rx_data    <= shift;
        parity_err <= par_bad;
        frame_err  <= stop_bad | ~bit_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx.
// Three receivers share clk/rst/rx_en: 8N1 at 100 clocks/bit, 8E1 at 100 clocks/bit,
// and 8N1 at 10 clocks/bit for the full 256-value loopback sweep.

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_en = 1'b1;
  logic       rx_n = 1'b1, rx_e = 1'b1, rx_f = 1'b1;
  logic [7:0] data_n, data_e, data_f;
  logic       vld_n, vld_e, vld_f;
  logic       pe_n, pe_e, pe_f;
  logic       fe_n, fe_e, fe_f;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int cnt_n = 0, cnt_e = 0, cnt_f = 0;
  int t_vld_n = 0, t_prev_n = 0, t_start = 0;
  int base;

  uart_rx #(.CLOCKRATE(100), .BAUDRATE(1000000), .DATA_BITS(8),
            .PARITY(uart_pkg::NONE), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .rx(rx_n), .rx_en(rx_en),
    .rx_data(data_n), .rx_valid(vld_n), .parity_err(pe_n), .frame_err(fe_n));

  uart_rx #(.CLOCKRATE(100), .BAUDRATE(1000000), .DATA_BITS(8),
            .PARITY(uart_pkg::EVEN), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .rx(rx_e), .rx_en(rx_en),
    .rx_data(data_e), .rx_valid(vld_e), .parity_err(pe_e), .frame_err(fe_e));

  uart_rx #(.CLOCKRATE(100), .BAUDRATE(10000000), .DATA_BITS(8),
            .PARITY(uart_pkg::NONE), .STOP_BITS(1)) u_f (
    .clk(clk), .rst(rst), .rx(rx_f), .rx_en(rx_en),
    .rx_data(data_f), .rx_valid(vld_f), .parity_err(pe_f), .frame_err(fe_f));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (vld_n) begin
      cnt_n    <= cnt_n + 1;
      t_prev_n <= t_vld_n;
      t_vld_n  <= cyc;
    end
    if (vld_e) cnt_e <= cnt_e + 1;
    if (vld_f) cnt_f <= cnt_f + 1;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, time %0t required below 2ms", $time);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int ln, input logic v);
    case (ln)
      0:       rx_n = v;
      1:       rx_e = v;
      default: rx_f = v;
    endcase
  endtask

  // start bit, nb payload bits (data then optional parity) LSB first, one stop bit;
  // the line is left at the stop level
  task automatic send(input int ln, input logic [8:0] d, input int nb, input logic stopb);
    int bp;
    logic [8:0] dd;
    bp = (ln == 2) ? 10 : 100;
    dd = d;
    if (ln == 0) t_start = cyc;
    drive(ln, 1'b0);
    wait_cyc(bp);
    for (int i = 0; i < nb; i++) begin
      drive(ln, dd[i]);
      wait_cyc(bp);
    end
    drive(ln, stopb);
    wait_cyc(bp);
  endtask

  initial begin
    wait_cyc(5);
    chk("rst_data", 32'(data_n), 32'h0);
    chk("rst_valid", 32'(vld_n), 32'h0);
    chk("rst_perr", 32'(pe_n), 32'h0);
    chk("rst_ferr", 32'(fe_n), 32'h0);
    rst = 1'b0;
    wait_cyc(10);

    // 8N1 frame 0xA5 with latency measurement
    send(0, 9'h0A5, 8, 1'b1);
    wait_cyc(20);
    chk("t1_pulses", 32'(cnt_n), 32'd1);
    chk("t1_data", 32'(data_n), 32'hA5);
    chk("t1_perr", 32'(pe_n), 32'h0);
    chk("t1_ferr", 32'(fe_n), 32'h0);
    chk("t1_latency", 32'(t_vld_n - t_start), 32'd953);

    // 20-cycle glitch is rejected, then a clean 0x3C
    rx_n = 1'b0;
    wait_cyc(20);
    rx_n = 1'b1;
    wait_cyc(200);
    chk("t2_glitch", 32'(cnt_n), 32'd1);
    send(0, 9'h03C, 8, 1'b1);
    wait_cyc(20);
    chk("t2_pulses", 32'(cnt_n), 32'd2);
    chk("t2_data", 32'(data_n), 32'h3C);

    // even parity: 0x07 has three ones, so parity bit 0 is wrong and 1 is right
    send(1, 9'h007, 9, 1'b1);
    wait_cyc(20);
    chk("t3_pulses_a", 32'(cnt_e), 32'd1);
    chk("t3_data_a", 32'(data_e), 32'h07);
    chk("t3_perr_a", 32'(pe_e), 32'h1);
    send(1, 9'h107, 9, 1'b1);
    wait_cyc(20);
    chk("t3_pulses_b", 32'(cnt_e), 32'd2);
    chk("t3_data_b", 32'(data_e), 32'h07);
    chk("t3_perr_b", 32'(pe_e), 32'h0);
    chk("t3_ferr_b", 32'(fe_e), 32'h0);

    // low stop bit, then break for 500 cycles, then recovery
    send(0, 9'h05A, 8, 1'b0);
    chk("t4_pulses", 32'(cnt_n), 32'd3);
    chk("t4_data", 32'(data_n), 32'h5A);
    chk("t4_ferr", 32'(fe_n), 32'h1);
    wait_cyc(500);
    chk("t4_break", 32'(cnt_n), 32'd3);
    rx_n = 1'b1;
    wait_cyc(50);
    chk("t4_break_high", 32'(cnt_n), 32'd3);
    send(0, 9'h011, 8, 1'b1);
    wait_cyc(20);
    chk("t4_recover_pulses", 32'(cnt_n), 32'd4);
    chk("t4_recover_data", 32'(data_n), 32'h11);
    chk("t4_recover_ferr", 32'(fe_n), 32'h0);

    // rx_en low ignores start bits; dropping rx_en mid-frame does not abort
    rx_en = 1'b0;
    send(0, 9'h099, 8, 1'b1);
    wait_cyc(20);
    chk("en_off_pulses", 32'(cnt_n), 32'd4);
    rx_en = 1'b1;
    wait_cyc(20);
    fork
      send(0, 9'h066, 8, 1'b1);
      begin
        wait_cyc(300);
        rx_en = 1'b0;
      end
    join
    wait_cyc(20);
    chk("en_mid_pulses", 32'(cnt_n), 32'd5);
    chk("en_mid_data", 32'(data_n), 32'h66);
    rx_en = 1'b1;
    wait_cyc(20);

    // back-to-back 0x00 then 0xFF with no idle gap
    send(0, 9'h000, 8, 1'b1);
    chk("t5_first_data", 32'(data_n), 32'h00);
    send(0, 9'h0FF, 8, 1'b1);
    wait_cyc(20);
    chk("t5_pulses", 32'(cnt_n), 32'd7);
    chk("t5_second_data", 32'(data_n), 32'hFF);
    chk("t5_spacing", 32'(t_vld_n - t_prev_n), 32'd1000);
    chk("t5_ferr", 32'(fe_n), 32'h0);

    // asynchronous reset in the middle of the data bits of 0x81
    rx_n = 1'b0;
    wait_cyc(100);
    rx_n = 1'b1;
    wait_cyc(100);
    rx_n = 1'b0;
    wait_cyc(150);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_data", 32'(data_n), 32'h0);
    chk("t6_async_valid", 32'(vld_n), 32'h0);
    chk("t6_async_ferr", 32'(fe_n), 32'h0);
    rx_n = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1200);
    chk("t6_aborted", 32'(cnt_n), 32'd7);
    send(0, 9'h042, 8, 1'b1);
    wait_cyc(20);
    chk("t6_pulses", 32'(cnt_n), 32'd8);
    chk("t6_data", 32'(data_n), 32'h42);

    // loopback sweep of every byte, frames back to back
    base = cnt_f;
    for (int v = 0; v < 256; v++) begin
      send(2, 9'(v), 8, 1'b1);
      chk("lb_word", {22'h0, pe_f, fe_f, data_f}, 32'(v));
    end
    rx_f = 1'b1;
    wait_cyc(20);
    chk("lb_pulses", 32'(cnt_f - base), 32'd256);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver paired with the team's UART transmitter, on the same parameter set (CLOCKRATE, BAUDRATE, DATA_BITS, PARITY, STOP_BITS).
- Samples the asynchronous rx line and reassembles frames: start bit, data LSB first, optional parity, stop bits.
- Presents each received word as a one-cycle valid pulse with error flags.
- Sits between the board/loopback rx pin and downstream consumers (FIFO, command decoder).

Parameters:
CLOCKRATE, 100, system clock frequency in MHz
BAUDRATE, 9600, line rate in bps
DATA_BITS, 8, data bits per frame (5..9)
PARITY, NONE, parity_t from uart_pkg: NONE, EVEN or ODD
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rx  input  1  serial line, asynchronous to clk, idle high
rx_en  input  1  enables start-bit detection
rx_data  output  DATA_BITS  last received word, held until the next frame completes
rx_valid  output  1  one-cycle pulse: rx_data and flags updated
parity_err  output  1  parity mismatch on the frame flagged by rx_valid
frame_err  output  1  a stop bit sampled low on the frame flagged by rx_valid

Behaviour:
- Reset is asynchronous and active-high: whenever rst is high, all state is cleared immediately.
  - Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, state=IDLE, counters 0, synchronizer flops=1.
- Reset mid-frame aborts the frame. No rx_valid is emitted for that frame.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
- CNTLIMIT = CLOCKRATE*1000000/BAUDRATE; HALF = CNTLIMIT/2.
- Bit counter width is $clog2(CNTLIMIT+1). Bit index width is $clog2(DATA_BITS+1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the previous rx_s is tracked. A 1->0 transition with rx_en=1 loads the counter with HALF and goes to START. With rx_en=0, falling edges are ignored.
  - START: count down to 0, then sample rx_s. If 0, reload CNTLIMIT and go to DATA with bit index 0. If 1, treat as a glitch/false start, return to IDLE and emit nothing.
  - DATA: at each count expiry, sample rx_s into shift register bit [index] (LSB first) and reload CNTLIMIT. After DATA_BITS samples, go to PARITY if PARITY!=NONE, else STOP.
  - PARITY: sample at expiry.
    - EVEN: XOR of data and parity bit must be 0.
    - ODD: XOR must be 1.
    - A mismatch is latched internally. Then go to STOP.
  - STOP: sample each of the STOP_BITS bits at expiry. Any 0 latches the frame error. After the last stop sample, in the same cycle:
    - register rx_data, parity_err and frame_err;
    - pulse rx_valid for exactly 1 cycle;
    - return to IDLE.
- Returning to IDLE mid-stop-bit allows back-to-back frames with no idle gap.
- Latency: rx_valid rises HALF + (DATA_BITS + (PARITY!=NONE) + STOP_BITS)*CNTLIMIT + 1 cycles after rx_s falls. rx_s lags rx by 2 cycles.
- rx_valid is a pulse with no backpressure. An unconsumed word is overwritten by the next frame.
- Error flags are only meaningful while rx_valid=1. They are held otherwise.
- A frame with frame_err still delivers rx_data.
- If a low stop bit is followed by line held low (break), IDLE waits for rx_s high before re-arming. No edge means no new frame.
- Deasserting rx_en mid-frame does not abort; the current frame completes.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, parity, stop) takes rx_s at expiry-1, expiry and expiry+1, and uses the 2-of-3 majority. The state advance and counter reload move to expiry+1, so latency grows by 1 cycle.
- Not defined: a single sample at expiry.

Test Plan:
All scenarios use CLOCKRATE=100, BAUDRATE=1000000 (CNTLIMIT=100), DATA_BITS=8, STOP_BITS=1, unless stated.
1. 8N1 frame 0xA5, rx_en=1 -> single rx_valid pulse ~953 cycles (±2) after the rx falling edge; rx_data=0xA5, parity_err=0, frame_err=0.
2. rx low pulse of 20 cycles, then high -> no rx_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
3. PARITY=EVEN, frame 0x07 with parity bit 0 (wrong) -> rx_valid, rx_data=0x07, parity_err=1. Same frame with parity bit 1 -> parity_err=0.
4. 0x5A with stop bit driven 0 -> rx_valid, rx_data=0x5A, frame_err=1. Line then held low 500 cycles -> no further rx_valid until rx returns high and a new start bit arrives.
5. Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses 1000 cycles apart, values correct, no errors.
6. rst pulsed mid-data of 0x81 -> outputs go to reset values asynchronously, no rx_valid. Next frame 0x42 after idle -> rx_data=0x42. Also loopback the transmitter to this receiver, sweeping all 256 values with no errors.
